// File: rtl/pixel_pkg.sv
// Shared types and default geometry for the raster pixel stream receiver.
package pixel_pkg;

  localparam int H_ACTIVE_DEF = 1024;
  localparam int V_ACTIVE_DEF = 768;
  localparam int DATA_W_DEF   = 24;
  localparam int X_W_DEF      = 10;
  localparam int Y_W_DEF      = 10;
  localparam int ADDR_W_DEF   = 20;

  typedef enum logic [1:0] {
    WAIT_SOF,
    RUN,
    WAIT_EOL
  } rx_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [X_W_DEF-1:0]    x;
    logic [Y_W_DEF-1:0]    y;
    logic [ADDR_W_DEF-1:0] addr;
  } pixel_beat_t;

endpackage

// File: rtl/pixel_out_reg.sv
// One-deep valid/ready output register; a beat transfers on valid && ready on either side.
module pixel_out_reg
  import pixel_pkg::*;
#(
  parameter type beat_t = pixel_beat_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  beat_t in_beat,
  output logic  out_valid,
  input  logic  out_ready,
  output beat_t out_beat
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_beat  <= in_beat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_stream_rx.sv
// Raster pixel stream receiver: recovers x/y/address, checks geometry, resyncs on sof.
// Optional PIXEL_RX_CHECKSUM_EN adds frame_sum, the per-frame sum of emitted pixel data.
module pixel_stream_rx
  import pixel_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_eol,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [X_W-1:0]    m_x,
  output logic [Y_W-1:0]    m_y,
  output logic [ADDR_W-1:0] m_addr,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              err_sof,
  output logic              err_eol
`ifdef PIXEL_RX_CHECKSUM_EN
  ,
  output logic [31:0]       frame_sum
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;
  } beat_t;

  localparam logic [X_W-1:0]    X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]    Y_LAST = Y_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

  rx_state_t         state, state_nx;
  logic [X_W-1:0]    x, x_nx, cx;
  logic [Y_W-1:0]    y, y_nx, cy;
  logic [ADDR_W-1:0] addr, addr_nx, caddr;
  logic [ADDR_W-1:0] base, base_nx, cbase;
  logic              accept, emit, run_mode, line_end;
  logic              done_nx, esof_nx, eeol_nx;
  beat_t             in_beat, out_beat;

  assign accept = s_valid && s_ready;

  // cx/cy/caddr/cbase are the position this pixel lands on; sof forces it back to (0,0).
  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    addr_nx  = addr;
    base_nx  = base;
    cx       = x;
    cy       = y;
    caddr    = addr;
    cbase    = base;
    run_mode = (state == RUN);
    emit     = 1'b0;
    line_end = 1'b0;
    done_nx  = 1'b0;
    esof_nx  = 1'b0;
    eeol_nx  = 1'b0;
    if (accept) begin
      if (s_sof) begin
        esof_nx  = (state != WAIT_SOF) && ((x != '0) || (y != '0));
        cx       = '0;
        cy       = '0;
        caddr    = '0;
        cbase    = '0;
        run_mode = 1'b1;
        x_nx     = '0;
        y_nx     = '0;
        addr_nx  = '0;
        base_nx  = '0;
        state_nx = RUN;
      end
      if (run_mode) begin
        emit = 1'b1;
        if (cx == X_LAST) begin
          if (s_eol) begin
            line_end = 1'b1;
          end else begin
            eeol_nx  = 1'b1;
            state_nx = WAIT_EOL;
          end
        end else if (s_eol) begin
          eeol_nx  = 1'b1;
          line_end = 1'b1;
        end else begin
          x_nx     = cx + 1'b1;
          addr_nx  = caddr + 1'b1;
          state_nx = RUN;
        end
      end else if ((state == WAIT_EOL) && s_eol) begin
        line_end = 1'b1;
      end
      if (line_end) begin
        if (cy == Y_LAST) begin
          done_nx  = 1'b1;
          x_nx     = '0;
          y_nx     = '0;
          addr_nx  = '0;
          base_nx  = '0;
          state_nx = WAIT_SOF;
        end else begin
          x_nx     = '0;
          y_nx     = cy + 1'b1;
          addr_nx  = cbase + H_STEP;
          base_nx  = cbase + H_STEP;
          state_nx = RUN;
        end
      end
    end
    in_beat.data = s_data;
    in_beat.x    = cx;
    in_beat.y    = cy;
    in_beat.addr = caddr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_SOF;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      base        <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
      err_sof     <= 1'b0;
      err_eol     <= 1'b0;
    end else begin
      state      <= state_nx;
      x          <= x_nx;
      y          <= y_nx;
      addr       <= addr_nx;
      base       <= base_nx;
      frame_done <= done_nx;
      err_sof    <= esof_nx;
      err_eol    <= eeol_nx;
      if (done_nx) frame_count <= frame_count + 16'd1;
    end
  end

  pixel_out_reg #(.beat_t(beat_t)) u_out (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (emit),
    .in_ready  (s_ready),
    .in_beat   (in_beat),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_beat  (out_beat)
  );

  assign m_data = out_beat.data;
  assign m_x    = out_beat.x;
  assign m_y    = out_beat.y;
  assign m_addr = out_beat.addr;

`ifdef PIXEL_RX_CHECKSUM_EN
  logic [31:0] acc, acc_nx;

  // An sof pixel starts a fresh sum that already includes its own data.
  always_comb begin
    acc_nx = acc;
    if (emit) acc_nx = (s_sof ? 32'd0 : acc) + 32'(s_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      frame_sum <= '0;
    end else begin
      acc <= acc_nx;
      if (done_nx) frame_sum <= acc_nx;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_stream_rx.sv
// Scoreboard bench for pixel_stream_rx on a 4x3 raster.
module tb_pixel_stream_rx;

  localparam int H = 4;
  localparam int V = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic        s_eol = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [23:0] m_data;
  logic [9:0]  m_x;
  logic [9:0]  m_y;
  logic [19:0] m_addr;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        err_sof;
  logic        err_eol;
`ifdef PIXEL_RX_CHECKSUM_EN
  logic [31:0] frame_sum;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          n_done = 0;
  int          n_esof = 0;
  int          n_eeol = 0;
  bit          bp_mode = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] held = '0;

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  pixel_stream_rx #(
    .H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(24), .X_W(10), .Y_W(10), .ADDR_W(20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .s_eol       (s_eol),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_x         (m_x),
    .m_y         (m_y),
    .m_addr      (m_addr),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .err_sof     (err_sof),
    .err_eol     (err_eol)
`ifdef PIXEL_RX_CHECKSUM_EN
    ,
    .frame_sum   (frame_sum)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Downstream ready: always 1, or toggling 1010... under backpressure
  always @(posedge clk) begin
    #1;
    m_ready = bp_mode ? ~m_ready : 1'b1;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [63:0] got;
    got = {m_data, m_x, m_y, m_addr};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_done) n_done++;
      if (err_sof) n_esof++;
      if (err_eol) n_eeol++;
      if (prev_stall && m_valid) check("stall_hold", got, held);
      if (m_valid && !m_ready) check("s_ready_stall", 64'(s_ready), 64'd0);
      if (m_valid && m_ready) begin
        check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("beat", got, exp_q.pop_front());
      end
      prev_stall = m_valid && !m_ready;
      held = got;
    end
  end

  // Driver tasks
  task automatic send(input logic [23:0] d, input bit sof, input bit eol,
                      input bit emit, input int x, input int y, input int a);
    int   n;
    logic rdy;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    n = 0;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 100);
    check("accept", 64'(rdy), 64'd1);
    if (emit) exp_q.push_back({d, 10'(x), 10'(y), 20'(a)});
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic send_line(input int y, input int x0, input bit sof);
    for (int x = x0; x < H; x++)
      send(24'($urandom_range(0, 24'hFFFFFF)), sof && (x == x0), x == H - 1, 1'b1, x, y, y * H + x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int d0, s0, e0;

  task automatic snap();
    d0 = n_done;
    s0 = n_esof;
    e0 = n_eeol;
  endtask

  task automatic expect_events(input string tag, input int dn, input int sn, input int en,
                               input int fc);
    check({tag, "_frame_done"}, 64'(n_done - d0), 64'(dn));
    check({tag, "_err_sof"}, 64'(n_esof - s0), 64'(sn));
    check({tag, "_err_eol"}, 64'(n_eeol - e0), 64'(en));
    check({tag, "_frame_count"}, 64'(frame_count), 64'(fc));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_pulses", 64'({frame_done, err_sof, err_eol}), 64'd0);
    rst = 1'b0;

    // Pixels before the first sof are dropped, then a clean frame with data 0..11
    snap();
    send(24'h123456, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    send(24'h654321, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < H * V; i++)
      send(24'(i), i == 0, (i % H) == H - 1, 1'b1, i % H, i / H, i);
    drain();
    expect_events("clean", 1, 0, 0, 1);
`ifdef PIXEL_RX_CHECKSUM_EN
    check("frame_sum", 64'(frame_sum), 64'd66);
`endif

    // Early eol on line 0 at x=1
    snap();
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b1, 1'b0, 1'b1, 0, 0, 0);
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b0, 1'b1, 1'b1, 1, 0, 1);
    send_line(1, 0, 1'b0);
    send_line(2, 0, 1'b0);
    drain();
    expect_events("early_eol", 1, 0, 1, 2);

    // Missing eol: line 1 carries 6 pixels, the last two are dropped
    snap();
    send_line(0, 0, 1'b1);
    for (int x = 0; x < H; x++)
      send(24'($urandom_range(0, 24'hFFFFFF)), 1'b0, 1'b0, 1'b1, x, 1, H + x);
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b0, 1'b1, 1'b0, 0, 0, 0);
    send_line(2, 0, 1'b0);
    drain();
    expect_events("missing_eol", 1, 0, 1, 3);

    // Sof arriving at (2,1) restarts the frame at (0,0)
    snap();
    send_line(0, 0, 1'b1);
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b0, 1'b0, 1'b1, 0, 1, H);
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b0, 1'b0, 1'b1, 1, 1, H + 1);
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b1, 1'b0, 1'b1, 0, 0, 0);
    send_line(0, 1, 1'b0);
    send_line(1, 0, 1'b0);
    send_line(2, 0, 1'b0);
    drain();
    expect_events("mid_sof", 1, 1, 0, 4);

    // Clean frame with downstream ready toggling
    snap();
    bp_mode = 1'b1;
    send_line(0, 0, 1'b1);
    send_line(1, 0, 1'b0);
    send_line(2, 0, 1'b0);
    drain();
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_events("backpressure", 1, 0, 0, 5);

    // Reset mid-frame discards the in-flight pixel and the frame count
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b1, 1'b0, 1'b1, 0, 0, 0);
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b0, 1'b0, 1'b1, 1, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_frame_count", 64'(frame_count), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    snap();
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b0, 1'b1, 1'b0, 0, 0, 0);
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b1, 1'b0, 1'b1, 0, 0, 0);
    send(24'($urandom_range(0, 24'hFFFFFF)), 1'b0, 1'b0, 1'b1, 1, 0, 1);
    drain();
    expect_events("after_rst", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
